if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipeline: owns the program counter, drives the instruction-memory port and the IF/ID pipeline register.
- Feeds the hazard detection unit. Instr_D from this block is the decode-stage instruction the HDU compares against.
- Consumes the HDU stall outputs (PC_H, ID_H), plus the hazard-gated PCSel and ALU_Out from execute for redirects.
- Has a one-entry skid buffer, so an instruction returned during a stall is never lost or refetched.

Parameters:
- AWIDTH, 32, address and instruction width.
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- PC_H  in  1  HDU stall request: hold the PC.
- ID_H  in  1  HDU stall request: hold IF/ID.
- PCSel  in  1  redirect request from execute (the HDU-gated PCSel_H).
- ALU_Out  in  AWIDTH  redirect target.
- imem_rdata  in  AWIDTH  instruction word.
- imem_valid  in  1  imem_rdata is valid for the current imem_addr this cycle.
- imem_addr  out  AWIDTH  fetch address.
- imem_req  out  1  fetch request.
- Instr_D  out  AWIDTH  IF/ID instruction.
- PC_D  out  AWIDTH  IF/ID PC.
- PC4_D  out  AWIDTH  IF/ID PC+4.
- Valid_D  out  1  IF/ID holds a real instruction.
- Misalign_F  out  1  sticky misaligned-redirect flag (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (async, takes effect immediately):
  - PC_F = RESET_PC.
  - Instr_D = 32'h0000_0013 (NOP).
  - PC_D = 0, PC4_D = 0, Valid_D = 0.
  - Skid buffer empty; Misalign_F = 0; state = S_BOOT.
  - Reset mid-fetch or mid-hold discards everything; no partial IF/ID update.
- Outputs:
  - imem_addr = PC_F.
  - imem_req = 1 only in S_FETCH.
  - stall = PC_H | ID_H.
- States:
  - S_BOOT: one idle cycle after reset release, then S_FETCH.
  - S_FETCH:
    - imem_valid & !stall: IF/ID <= {imem_rdata, PC_F, PC_F+4, 1}; PC_F <= PC_F+4.
    - imem_valid & stall: skid <= {imem_rdata, PC_F}; go to S_HOLD. PC_F and IF/ID hold.
    - !imem_valid & !stall: IF/ID <= bubble (NOP, Valid_D=0); PC_F holds.
    - !imem_valid & stall: everything holds.
  - S_HOLD:
    - imem_req = 0.
    - While stall: hold.
    - When !stall: IF/ID <= skid contents with Valid_D=1; PC_F <= PC_F+4; go to S_FETCH.
- Redirect (PCSel=1) has highest priority, in any state except S_BOOT, and overrides stall:
  - PC_F <= {ALU_Out[AWIDTH-1:2], 2'b00}.
  - IF/ID <= bubble; skid cleared; go to S_FETCH.
  - The same-cycle imem response is dropped.
- PC arithmetic is modulo 2^AWIDTH; 32'hFFFF_FFFC + 4 wraps to 0.
- Latency:
  - First imem_req is 1 cycle after reset release.
  - With single-cycle memory and no stalls: one instruction per cycle; Instr_D valid 1 cycle after imem_valid.
  - Redirect to first target fetch: 1 cycle.

Optional Feature:
- Macro: IF_MISALIGN_TRAP_EN.
- Defined:
  - A redirect with ALU_Out[1:0] != 0 sets Misalign_F=1 and enters S_TRAP.
  - S_TRAP: imem_req=0, IF/ID forced to bubble, PC_F = raw ALU_Out. Exits only on rst.
  - An aligned redirect behaves as normal.
- Undefined:
  - Low two bits of the target are forced to 0, as above.
  - No S_TRAP state exists; Misalign_F is tied to 0.

Decomposition:
- Shared package pssrvp_pkg: NOP_INSTR = 32'h0000_0013, RESET_PC default, and the fetch-state encoding (S_BOOT, S_FETCH, S_HOLD, S_TRAP).
- One natural sub-module, ifid_reg: the IF/ID register with load, hold and bubble controls and an async reset. Reused by the top for the skid path.

Test Plan:
- Reset, then a single-cycle memory returning the address as data → imem_addr goes 0, 4, 8; Instr_D goes 0, 4, 8 each cycle; Valid_D=1 from cycle 2.
- ID_H=PC_H=1 for 3 cycles while imem_valid=1 at PC=8 → Instr_D stays at PC 4's word; state S_HOLD with imem_req=0. On release, Instr_D=word@8 with PC_D=8, then fetch resumes at 12 with no duplicate and no skip.
- imem_valid=0 for 2 cycles at PC=0x10, no stall → 2 bubbles (Instr_D=0x13, Valid_D=0); PC holds at 0x10.
- PCSel=1 with ALU_Out=0x200 during a stall → next cycle PC_F=0x200, Instr_D=NOP, Valid_D=0, skid empty.
- PCSel=1 with ALU_Out=0x102 → without the macro, PC_F=0x100. With IF_MISALIGN_TRAP_EN, Misalign_F=1 and imem_req=0 until rst.
- Assert rst while in S_HOLD with a full skid → outputs return to reset values immediately; first fetch after release is at RESET_PC.

Source files
------------

// File: rtl/pssrvp_pkg.sv
// Shared pipeline definitions: NOP encoding, default reset PC and fetch-state encoding.
package pssrvp_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_TRAP  = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/if_stage_ifid_reg.sv
// IF/ID style register: bubble beats load, otherwise holds. Also used as the fetch skid buffer.
module ifid_reg
  import pssrvp_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         bubble,
  input  logic [W-1:0] instr,
  input  logic [W-1:0] pc,
  input  logic [W-1:0] pc4,
  input  logic         valid,
  output logic [W-1:0] instr_q,
  output logic [W-1:0] pc_q,
  output logic [W-1:0] pc4_q,
  output logic         valid_q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= W'(NOP_INSTR);
      pc_q    <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else if (bubble) begin
      instr_q <= W'(NOP_INSTR);
      pc_q    <= '0;
      pc4_q   <= '0;
      valid_q <= 1'b0;
    end else if (load) begin
      instr_q <= instr;
      pc_q    <= pc;
      pc4_q   <= pc4;
      valid_q <= valid;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, imem port, one-entry skid buffer and IF/ID register.
// Optional misaligned-redirect trap enabled by defining IF_MISALIGN_TRAP_EN.
module if_stage
  import pssrvp_pkg::*;
#(
  parameter int unsigned         AWIDTH   = 32,
  parameter logic [AWIDTH-1:0]   RESET_PC = AWIDTH'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              PC_H,
  input  logic              ID_H,
  input  logic              PCSel,
  input  logic [AWIDTH-1:0] ALU_Out,
  input  logic [AWIDTH-1:0] imem_rdata,
  input  logic              imem_valid,
  output logic [AWIDTH-1:0] imem_addr,
  output logic              imem_req,
  output logic [AWIDTH-1:0] Instr_D,
  output logic [AWIDTH-1:0] PC_D,
  output logic [AWIDTH-1:0] PC4_D,
  output logic              Valid_D,
  output logic              Misalign_F
);

  fetch_state_t      state, state_next;
  logic [AWIDTH-1:0] pc_f, pc_next, pc_plus4;
  logic              stall;
  logic              ifid_load, ifid_bubble, use_skid;
  logic              skid_load, skid_clear;
  logic [AWIDTH-1:0] skid_instr, skid_pc, skid_pc4;
  logic              skid_valid;
  logic              misalign_set;

  assign stall     = PC_H | ID_H;
  assign pc_plus4  = pc_f + AWIDTH'(4);
  assign imem_addr = pc_f;

  always_comb begin
    state_next   = state;
    pc_next      = pc_f;
    imem_req     = 1'b0;
    ifid_load    = 1'b0;
    ifid_bubble  = 1'b0;
    use_skid     = 1'b0;
    skid_load    = 1'b0;
    skid_clear   = 1'b0;
    misalign_set = 1'b0;

    case (state)
      S_BOOT: state_next = S_FETCH;
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_valid && !stall) begin
          ifid_load = 1'b1;
          pc_next   = pc_plus4;
        end else if (imem_valid && stall) begin
          skid_load  = 1'b1;
          state_next = S_HOLD;
        end else if (!imem_valid && !stall) begin
          ifid_bubble = 1'b1;
        end
      end
      S_HOLD: begin
        if (!stall) begin
          ifid_load  = 1'b1;
          use_skid   = 1'b1;
          skid_clear = 1'b1;
          pc_next    = pc_plus4;
          state_next = S_FETCH;
        end
      end
      default: ifid_bubble = 1'b1;  // S_TRAP: sticky until reset
    endcase

    // Redirect wins over stall and any same-cycle imem response.
    if (PCSel && (state == S_FETCH || state == S_HOLD)) begin
      ifid_load   = 1'b0;
      skid_load   = 1'b0;
      use_skid    = 1'b0;
      ifid_bubble = 1'b1;
      skid_clear  = 1'b1;
      state_next  = S_FETCH;
      pc_next     = {ALU_Out[AWIDTH-1:2], 2'b00};
`ifdef IF_MISALIGN_TRAP_EN
      if (ALU_Out[1:0] != 2'b00) begin
        pc_next      = ALU_Out;
        misalign_set = 1'b1;
        state_next   = S_TRAP;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_BOOT;
      pc_f  <= RESET_PC;
    end else begin
      state <= state_next;
      pc_f  <= pc_next;
    end
  end

`ifdef IF_MISALIGN_TRAP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) Misalign_F <= 1'b0;
    else if (misalign_set) Misalign_F <= 1'b1;
  end
`else
  logic unused_low_bits;
  assign unused_low_bits = ^{ALU_Out[1:0], misalign_set};
  assign Misalign_F      = 1'b0;
`endif

  ifid_reg #(.W(AWIDTH)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .load    (skid_load),
    .bubble  (skid_clear),
    .instr   (imem_rdata),
    .pc      (pc_f),
    .pc4     (pc_plus4),
    .valid   (1'b1),
    .instr_q (skid_instr),
    .pc_q    (skid_pc),
    .pc4_q   (skid_pc4),
    .valid_q (skid_valid)
  );

  ifid_reg #(.W(AWIDTH)) u_ifid (
    .clk     (clk),
    .rst     (rst),
    .load    (ifid_load),
    .bubble  (ifid_bubble),
    .instr   (use_skid ? skid_instr : imem_rdata),
    .pc      (use_skid ? skid_pc    : pc_f),
    .pc4     (use_skid ? skid_pc4   : pc_plus4),
    .valid   (use_skid ? skid_valid : 1'b1),
    .instr_q (Instr_D),
    .pc_q    (PC_D),
    .pc4_q   (PC4_D),
    .valid_q (Valid_D)
  );

endmodule

// File: tb/tb_if_stage.sv
// Scoreboarded bench for if_stage: memory returns the address as data; a monitor
// pops expected IF/ID entries whenever a new valid instruction appears.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        PC_H, ID_H, PCSel;
  logic [31:0] ALU_Out;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] imem_addr;
  logic        imem_req;
  logic [31:0] Instr_D, PC_D, PC4_D;
  logic        Valid_D, Misalign_F;
  logic        mem_en;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  assign imem_valid = mem_en & imem_req;
  assign imem_rdata = imem_addr;

  if_stage #(.AWIDTH(32), .RESET_PC(32'h0)) dut (
    .clk        (clk),
    .rst        (rst),
    .PC_H       (PC_H),
    .ID_H       (ID_H),
    .PCSel      (PCSel),
    .ALU_Out    (ALU_Out),
    .imem_rdata (imem_rdata),
    .imem_valid (imem_valid),
    .imem_addr  (imem_addr),
    .imem_req   (imem_req),
    .Instr_D    (Instr_D),
    .PC_D       (PC_D),
    .PC4_D      (PC4_D),
    .Valid_D    (Valid_D),
    .Misalign_F (Misalign_F)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc);
    exp_t e;
    e.instr = pc;
    e.pc    = pc;
    exp_q.push_back(e);
  endtask

  // Monitor: a new IF/ID entry is a valid one that differs from last cycle's.
  logic        prev_valid = 1'b0;
  logic [31:0] prev_pc    = '0;
  always @(negedge clk) begin
    if (rst) begin
      prev_valid <= 1'b0;
    end else begin
      if (Valid_D && !(prev_valid && prev_pc == PC_D)) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_instr", PC_D, 32'hDEAD_BEEF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_instr", Instr_D, e.instr);
          chk("sb_pc", PC_D, e.pc);
          chk("sb_pc4", PC4_D, e.pc + 32'd4);
        end
      end
      prev_valid <= Valid_D;
      prev_pc    <= PC_D;
    end
  end

  initial begin
    rst = 1'b1; PC_H = 1'b0; ID_H = 1'b0; PCSel = 1'b0; ALU_Out = '0; mem_en = 1'b1;
    #1;
    chk("rst_instr", Instr_D, 32'h13);
    chk("rst_pc_d", PC_D, 32'h0);
    chk("rst_valid", {31'b0, Valid_D}, 32'd0);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_misalign", {31'b0, Misalign_F}, 32'd0);
    #11 rst = 1'b0;

    // Boot cycle, then streaming fetch 0,4,8
    step();
    chk("boot_req", {31'b0, imem_req}, 32'd1);
    chk("addr0", imem_addr, 32'h0);
    push(32'h0); push(32'h4); push(32'h8); push(32'hC); push(32'h10);
    step();
    chk("addr4", imem_addr, 32'h4);
    step();
    chk("addr8", imem_addr, 32'h8);
    PC_H = 1'b1; ID_H = 1'b1;

    // Stall three cycles with a response captured into the skid
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_req", {31'b0, imem_req}, 32'd0);
      chk("hold_instr", Instr_D, 32'h4);
      chk("hold_addr", imem_addr, 32'h8);
    end
    PC_H = 1'b0; ID_H = 1'b0;
    step();
    chk("release_instr", Instr_D, 32'h8);
    chk("release_pc_d", PC_D, 32'h8);
    chk("resume_addr", imem_addr, 32'hC);
    step();
    chk("addr10", imem_addr, 32'h10);
    mem_en = 1'b0;

    // Two bubbles with no memory response
    for (int i = 0; i < 2; i++) begin
      step();
      chk("bubble_instr", Instr_D, 32'h13);
      chk("bubble_valid", {31'b0, Valid_D}, 32'd0);
      chk("bubble_pc_hold", imem_addr, 32'h10);
    end
    mem_en = 1'b1;
    step();
    chk("after_bubble_addr", imem_addr, 32'h14);

    // Redirect during a stall
    PC_H = 1'b1; ID_H = 1'b1;
    step();
    chk("hold2_req", {31'b0, imem_req}, 32'd0);
    PCSel = 1'b1; ALU_Out = 32'h200;
    step();
    chk("redir_addr", imem_addr, 32'h200);
    chk("redir_instr", Instr_D, 32'h13);
    chk("redir_valid", {31'b0, Valid_D}, 32'd0);
    chk("redir_req", {31'b0, imem_req}, 32'd1);
    PCSel = 1'b0; PC_H = 1'b0; ID_H = 1'b0;
    push(32'h200);
    step();
    chk("target_instr", Instr_D, 32'h200);
    chk("target_next_addr", imem_addr, 32'h204);

    // Misaligned redirect
    PCSel = 1'b1; ALU_Out = 32'h102;
    step();
    PCSel = 1'b0;
    chk("mis_instr", Instr_D, 32'h13);
    chk("mis_valid", {31'b0, Valid_D}, 32'd0);
`ifdef IF_MISALIGN_TRAP_EN
    chk("trap_addr", imem_addr, 32'h102);
    for (int i = 0; i < 3; i++) begin
      chk("trap_flag", {31'b0, Misalign_F}, 32'd1);
      chk("trap_req", {31'b0, imem_req}, 32'd0);
      step();
    end
    chk("trap_valid", {31'b0, Valid_D}, 32'd0);
`else
    chk("align_addr", imem_addr, 32'h100);
    chk("align_flag", {31'b0, Misalign_F}, 32'd0);
    push(32'h100);
    step();
    chk("align_instr", Instr_D, 32'h100);
    PC_H = 1'b1; ID_H = 1'b1;
    step();
`endif

    // Reset pulse, then reset while holding a full skid
    rst = 1'b1;
    step();
    rst = 1'b0; PC_H = 1'b0; ID_H = 1'b0;
    chk("rst2_misalign", {31'b0, Misalign_F}, 32'd0);
    step();
    chk("fetch0_addr", imem_addr, 32'h0);
    PC_H = 1'b1; ID_H = 1'b1;
    step();
    chk("hold3_req", {31'b0, imem_req}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_instr", Instr_D, 32'h13);
    chk("async_rst_valid", {31'b0, Valid_D}, 32'd0);
    chk("async_rst_req", {31'b0, imem_req}, 32'd0);
    chk("async_rst_addr", imem_addr, 32'h0);
    step();
    rst = 1'b0; PC_H = 1'b0; ID_H = 1'b0;
    step();
    chk("refetch_addr", imem_addr, 32'h0);
    chk("refetch_req", {31'b0, imem_req}, 32'd1);
    push(32'h0);
    step();
    chk("refetch_instr", Instr_D, 32'h0);
    chk("refetch_pc4", PC4_D, 32'h4);
    PC_H = 1'b1; ID_H = 1'b1;
    step();
    step();
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, required finish before 20000");
    $fatal(1);
  end

endmodule
